// File: rtl/fir_filter_pipelined_if.sv
// Sample, coefficient-write and result signals of the pipelined FIR filter.
// The master drives samples and coefficient writes. The slave (the filter) returns results.
interface fir_filter_pipelined_if #(
    parameter int TAPS   = 8,
    parameter int DATA_W = 16,
    parameter int COEF_W = 8,
    parameter int OUT_W  = 32
);
    localparam int ADDR_W = $clog2(TAPS);

    logic                     clear_i;
    logic                     in_valid_i;
    logic signed [DATA_W-1:0] in_data_i;
    logic                     coef_we_i;
    logic [ADDR_W-1:0]        coef_addr_i;
    logic signed [COEF_W-1:0] coef_data_i;
    logic signed [OUT_W-1:0]  out_data_o;
    logic                     out_valid_o;
    logic signed [DATA_W-1:0] sample_t_o;

    modport master (
        output clear_i, in_valid_i, in_data_i, coef_we_i, coef_addr_i, coef_data_i,
        input  out_data_o, out_valid_o, sample_t_o
    );

    modport slave (
        input  clear_i, in_valid_i, in_data_i, coef_we_i, coef_addr_i, coef_data_i,
        output out_data_o, out_valid_o, sample_t_o
    );
endinterface

// File: rtl/fir_filter_pipelined.sv
// Pipelined direct-form FIR filter with runtime-writable coefficients and rounded, saturated or wrapped output.
// Registered products feed a registered sum. A result appears two cycles after its sample is presented.
module fir_filter_pipelined #(
    parameter int TAPS     = 8,
    parameter int DATA_W   = 16,
    parameter int COEF_W   = 8,
    parameter int OUT_W    = 32,
    parameter int SHIFT    = 0,
    parameter int SAT      = 1,
    parameter int COEF_RST = 16
) (
    input  logic clk,
    input  logic rst_n,
    fir_filter_pipelined_if.slave bus
);
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = PROD_W + $clog2(TAPS);
    localparam int RND_W  = ACC_W + 1;
    localparam logic signed [RND_W-1:0] RND_BIAS = RND_W'((64'sd1 <<< SHIFT) >>> 1);

    logic signed [COEF_W-1:0] coef_q [TAPS];
    logic signed [DATA_W-1:0] dly_q  [TAPS-1];
    logic signed [DATA_W-1:0] tap_in [TAPS];
    logic signed [PROD_W-1:0] prod_d [TAPS];
    logic signed [PROD_W-1:0] prod_q [TAPS];
    logic                     v1_q;
    logic signed [ACC_W-1:0]  acc_sum;
    logic signed [RND_W-1:0]  acc_scaled;
    logic signed [OUT_W-1:0]  out_d;
    logic signed [OUT_W-1:0]  out_q;
    logic                     out_valid_q;

    // NOTE: the coefficient array is a small register file with a defined power-up value, so it sits
    // on the async reset like any other state. A RAM-style array with no reset would come up random.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < TAPS; k++) coef_q[k] <= COEF_W'(COEF_RST);
        end else if (bus.coef_we_i && (int'(bus.coef_addr_i) < TAPS)) begin
            coef_q[bus.coef_addr_i] <= bus.coef_data_i;
        end
    end

    // NOTE: every variable assigned here gets a value on every pass, so no latch can be inferred.
    always_comb begin
        tap_in[0] = bus.in_data_i;
        for (int k = 1; k < TAPS; k++) tap_in[k] = dly_q[k-1];
        for (int k = 0; k < TAPS; k++) prod_d[k] = PROD_W'(coef_q[k]) * PROD_W'(tap_in[k]);
    end

    // NOTE: all sequential state uses non-blocking assignments, so each shift stage reads the pre-edge value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < TAPS-1; k++) dly_q[k] <= '0;
            for (int k = 0; k < TAPS; k++) prod_q[k] <= '0;
            v1_q <= 1'b0;
        end else if (bus.clear_i) begin
            for (int k = 0; k < TAPS-1; k++) dly_q[k] <= '0;
            for (int k = 0; k < TAPS; k++) prod_q[k] <= '0;
            v1_q <= 1'b0;
        end else begin
            v1_q <= bus.in_valid_i;
            if (bus.in_valid_i) begin
                for (int k = 0; k < TAPS-1; k++) dly_q[k] <= tap_in[k];
                for (int k = 0; k < TAPS; k++) prod_q[k] <= prod_d[k];
            end
        end
    end

    always_comb begin
        acc_sum = '0;
        for (int k = 0; k < TAPS; k++) acc_sum = acc_sum + ACC_W'(prod_q[k]);
        acc_scaled = (RND_W'(acc_sum) + RND_BIAS) >>> SHIFT;
    end

    // Saturation only matters when the scaled accumulator can exceed the output range.
    if (OUT_W >= RND_W) begin : g_wide
        assign out_d = OUT_W'(acc_scaled);
    end else if (SAT != 0) begin : g_sat
        localparam logic signed [RND_W-1:0] OUT_MAX = RND_W'((64'sd1 <<< (OUT_W-1)) - 1);
        localparam logic signed [RND_W-1:0] OUT_MIN = -OUT_MAX - RND_W'(1);
        always_comb begin
            if (acc_scaled > OUT_MAX)      out_d = OUT_MAX[OUT_W-1:0];
            else if (acc_scaled < OUT_MIN) out_d = OUT_MIN[OUT_W-1:0];
            else                           out_d = acc_scaled[OUT_W-1:0];
        end
    end else begin : g_wrap
        assign out_d = acc_scaled[OUT_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else if (bus.clear_i) begin
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= v1_q;
            if (v1_q) out_q <= out_d;
        end
    end

    assign bus.out_data_o  = out_q;
    assign bus.out_valid_o = out_valid_q;
    assign bus.sample_t_o  = dly_q[0];
endmodule

// File: tb/tb_fir_filter_pipelined.sv
// Bench for fir_filter_pipelined: five configurations share one stimulus stream.
// Each configuration has its own reference model, scoreboard and output monitor.
module tb_fir_filter_pipelined;
    localparam int N_DUT = 5;
    localparam int P_TAPS  [N_DUT] = '{8, 8, 8, 8, 6};
    localparam int P_OUT_W [N_DUT] = '{32, 16, 16, 32, 16};
    localparam int P_SHIFT [N_DUT] = '{0, 0, 0, 4, 2};
    localparam int P_SAT   [N_DUT] = '{1, 1, 0, 1, 1};

    typedef struct {
        longint val;
        int     due;
    } exp_t;

    logic               clk       = 1'b0;
    logic               rst_n     = 1'b0;
    logic               clear     = 1'b0;
    logic               in_valid  = 1'b0;
    logic signed [15:0] in_data   = '0;
    logic               coef_we   = 1'b0;
    logic [2:0]         coef_addr = '0;
    logic signed [7:0]  coef_data = '0;
    int                 cyc       = 0;
    int                 checks    = 0;
    int                 errors    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // The ideal filter output: round half up, arithmetic shift, then clamp or wrap to ow bits.
    function automatic longint scale(input longint sum, input int shift, input int sat, input int ow);
        longint r;
        longint lim;
        r = sum;
        if (shift > 0) r = (r + (longint'(1) <<< (shift - 1))) >>> shift;
        lim = longint'(1) <<< (ow - 1);
        if (sat != 0) begin
            if (r > lim - 1)   r = lim - 1;
            else if (r < -lim) r = -lim;
        end else begin
            r = r & ((lim <<< 1) - 1);
            if (r >= lim) r = r - (lim <<< 1);
        end
        return r;
    endfunction

    for (genvar g = 0; g < N_DUT; g++) begin : g_inst
        localparam int T  = P_TAPS[g];
        localparam int OW = P_OUT_W[g];
        localparam int SH = P_SHIFT[g];
        localparam int ST = P_SAT[g];

        fir_filter_pipelined_if #(.TAPS(T), .DATA_W(16), .COEF_W(8), .OUT_W(OW)) ifc ();

        assign ifc.clear_i     = clear;
        assign ifc.in_valid_i  = in_valid;
        assign ifc.in_data_i   = in_data;
        assign ifc.coef_we_i   = coef_we;
        assign ifc.coef_addr_i = coef_addr;
        assign ifc.coef_data_i = coef_data;

        fir_filter_pipelined #(
            .TAPS(T), .DATA_W(16), .COEF_W(8), .OUT_W(OW),
            .SHIFT(SH), .SAT(ST), .COEF_RST(16)
        ) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (ifc.slave)
        );

        longint coef_m [T];
        longint hist_m [T];
        longint head_m;
        longint last_out;
        longint sum_m;
        exp_t   mon_e;
        exp_t   sb [$];

        // Reference model: the window of the last T accepted samples (newest first) and the coefficients.
        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                foreach (coef_m[k]) coef_m[k] = 16;
                foreach (hist_m[k]) hist_m[k] = 0;
                head_m   = 0;
                last_out = 0;
                sb.delete();
            end else begin
                if (clear) begin
                    foreach (hist_m[k]) hist_m[k] = 0;
                    head_m = 0;
                    while (sb.size() > 0 && sb[$].due > cyc) void'(sb.pop_back());
                end else if (in_valid) begin
                    for (int k = T - 1; k > 0; k--) hist_m[k] = hist_m[k-1];
                    hist_m[0] = longint'(in_data);
                    head_m    = hist_m[0];
                    sum_m     = 0;
                    for (int k = 0; k < T; k++) sum_m += coef_m[k] * hist_m[k];
                    sb.push_back('{scale(sum_m, SH, ST, OW), cyc + 2});
                end
                if (coef_we && int'(coef_addr) < T) coef_m[coef_addr] = longint'(coef_data);
            end
        end

        always @(negedge clk) begin
            if (!rst_n) begin
                check($sformatf("u%0d reset out_valid", g), longint'(ifc.out_valid_o), 0);
                check($sformatf("u%0d reset out_data", g), longint'(ifc.out_data_o), 0);
                check($sformatf("u%0d reset sample_t", g), longint'(ifc.sample_t_o), 0);
            end else begin
                if (ifc.out_valid_o) begin
                    if (sb.size() == 0) begin
                        check($sformatf("u%0d spurious out_valid", g), longint'(ifc.out_valid_o), 0);
                    end else begin
                        mon_e = sb.pop_front();
                        check($sformatf("u%0d latency", g), longint'(cyc), longint'(mon_e.due));
                        check($sformatf("u%0d out_data", g), longint'(ifc.out_data_o), mon_e.val);
                        last_out = mon_e.val;
                    end
                end else begin
                    check($sformatf("u%0d hold out_data", g), longint'(ifc.out_data_o), last_out);
                    if (sb.size() > 0 && sb[0].due <= cyc) begin
                        check($sformatf("u%0d missing out_valid", g), longint'(ifc.out_valid_o), 1);
                        void'(sb.pop_front());
                    end
                end
                check($sformatf("u%0d sample_t", g), longint'(ifc.sample_t_o), head_m);
            end
        end
    end

    task automatic drive(input logic v, input logic signed [15:0] d, input logic clr = 1'b0,
                         input logic we = 1'b0, input logic [2:0] a = 3'd0,
                         input logic signed [7:0] cd = 8'sd0);
        in_valid  = v;
        in_data   = d;
        clear     = clr;
        coef_we   = we;
        coef_addr = a;
        coef_data = cd;
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 16'sd0);
    endtask

    task automatic impulse(input logic signed [15:0] amp, input int zeros);
        drive(1'b1, amp);
        repeat (zeros) drive(1'b1, 16'sd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic signed [15:0] rd;
        int                 r;

        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        idle(2);

        // Impulse with the reset coefficients.
        drive(1'b1, 16'sd1);
        drive(1'b1, 16'sd0);
        check("u0 impulse first out", longint'(g_inst[0].ifc.out_data_o), 16);
        repeat (8) drive(1'b1, 16'sd0);
        idle(3);
        check("u0 impulse tail", longint'(g_inst[0].ifc.out_data_o), 0);

        // Step of 1000 presented every other cycle.
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, 16'sd1000);
            drive(1'b0, 16'sd0);
        end
        check("u0 step steady", longint'(g_inst[0].ifc.out_data_o), 128000);
        check("u0 step sample_t", longint'(g_inst[0].ifc.sample_t_o), 1000);
        check("u1 step saturated", longint'(g_inst[1].ifc.out_data_o), 32767);

        // Full-scale constants to drive saturation and wrap.
        drive(1'b0, 16'sd0, 1'b1);
        repeat (10) drive(1'b1, 16'sd32767);
        idle(2);
        check("u0 max full precision", longint'(g_inst[0].ifc.out_data_o), 4194176);
        check("u1 max clamp", longint'(g_inst[1].ifc.out_data_o), 32767);
        check("u2 max wrap", longint'(g_inst[2].ifc.out_data_o), -128);
        repeat (10) drive(1'b1, -16'sd32768);
        idle(2);
        check("u0 min full precision", longint'(g_inst[0].ifc.out_data_o), -4194304);
        check("u1 min clamp", longint'(g_inst[1].ifc.out_data_o), -32768);

        // Coefficient write alongside a sample, then an impulse through the new coefficients.
        drive(1'b0, 16'sd0, 1'b1);
        drive(1'b1, 16'sd7, 1'b0, 1'b1, 3'd3, -8'sd5);
        idle(3);
        drive(1'b0, 16'sd0, 1'b1);
        impulse(16'sd100, 8);
        idle(3);

        // Writes to addresses 6 and 7 are out of range only for the six-tap instance.
        drive(1'b0, 16'sd0, 1'b0, 1'b1, 3'd6, -8'sd100);
        drive(1'b0, 16'sd0, 1'b0, 1'b1, 3'd7, -8'sd100);
        drive(1'b0, 16'sd0, 1'b1);
        impulse(16'sd100, 8);
        idle(3);

        // Clear together with a sample, and clear together with a coefficient write.
        drive(1'b1, 16'sd500);
        drive(1'b1, 16'sd600, 1'b1);
        idle(3);
        drive(1'b0, 16'sd0, 1'b1, 1'b1, 3'd0, -8'sd1);
        impulse(16'sd3, 8);
        idle(3);

        // Rounding: every coefficient 8, impulses of +1 and -1.
        for (int k = 0; k < 8; k++) drive(1'b0, 16'sd0, 1'b0, 1'b1, 3'(k), 8'sd8);
        drive(1'b0, 16'sd0, 1'b1);
        drive(1'b1, 16'sd1);
        drive(1'b1, 16'sd0);
        check("u3 round +1", longint'(g_inst[3].ifc.out_data_o), 1);
        repeat (8) drive(1'b1, 16'sd0);
        drive(1'b1, -16'sd1);
        drive(1'b1, 16'sd0);
        check("u3 round -1", longint'(g_inst[3].ifc.out_data_o), 0);
        repeat (8) drive(1'b1, 16'sd0);
        idle(3);

        // Asynchronous reset with samples in flight.
        repeat (3) drive(1'b1, 16'sd1234);
        rst_n = 1'b0;
        #1;
        check("u0 async reset out_data", longint'(g_inst[0].ifc.out_data_o), 0);
        check("u0 async reset out_valid", longint'(g_inst[0].ifc.out_valid_o), 0);
        idle(2);
        rst_n = 1'b1;
        idle(4);
        drive(1'b1, 16'sd1);
        drive(1'b1, 16'sd0);
        check("u0 coef reset value", longint'(g_inst[0].ifc.out_data_o), 16);
        repeat (8) drive(1'b1, 16'sd0);
        idle(2);

        // Randomised traffic with occasional writes, clears and extreme samples.
        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 5)       rd = -16'sd32768;
            else if (r < 10) rd = 16'sd32767;
            else             rd = 16'($urandom);
            drive($urandom_range(0, 9) < 7, rd, $urandom_range(0, 49) == 0,
                  $urandom_range(0, 19) == 0, 3'($urandom_range(0, 7)), 8'($urandom));
        end
        idle(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
